imem_port_arbiter: RTL and testbench

- Shares the single-port instruction memory between two requesters: the IF fetch unit (port F) and a loader/debug master (port L). L is used for boot-image checks and memory inspection.
- Grants are same-cycle. The block drives the memory's chip select and word address and routes each read response back to its owner after the fixed memory latency.
- Supports a fetch flush (on IF Jump redirect), which kills in-flight fetch responses so stale instructions never reach IF.

---
 rtl/imem_port_arbiter.sv | 77 +++++++
 tb/tb_imem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - instruction memory arbiter between fetch (F) and loader (L) ports
// Same-cycle grants, starvation-bounded F priority, latency-matched response routing with fetch flush.
module imem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_dout
);

  logic [3:0]         starve_cnt;
  logic               force_l;
  logic [AW-1:0]      sel_addr;
  // Per-stage response tags; owner bit is 1 for L.
  logic [MEM_LAT-1:0] pipe_valid;
  logic [MEM_LAT-1:0] pipe_owner;
  logic [MEM_LAT-1:0] pipe_killed;

  assign force_l = l_req && (starve_cnt == 4'(STARVE_MAX));

  always_comb begin
    l_gnt    = !rst && l_req && (!f_req || force_l);
    f_gnt    = !rst && f_req && !force_l;
    mem_cs   = f_gnt || l_gnt;
    sel_addr = l_gnt ? l_addr : (f_gnt ? f_addr : '0);
    mem_addr = sel_addr >> 2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= 4'd0;
      pipe_valid  <= '0;
      pipe_owner  <= '0;
      pipe_killed <= '0;
    end else begin
      if (!l_req || l_gnt)
        starve_cnt <= 4'd0;
      else if (f_gnt)
        starve_cnt <= starve_cnt + 4'd1;

      // The entry leaving the last stage this cycle is already being delivered and is not re-killed.
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pipe_valid[i]  <= pipe_valid[i-1];
        pipe_owner[i]  <= pipe_owner[i-1];
        pipe_killed[i] <= pipe_killed[i-1] | (f_flush & pipe_valid[i-1] & ~pipe_owner[i-1]);
      end
      // A same-cycle F grant is the redirect target, so it enters unkilled.
      pipe_valid[0]  <= mem_cs;
      pipe_owner[0]  <= l_gnt;
      pipe_killed[0] <= 1'b0;
    end
  end

  always_comb begin
    f_rvalid = !rst && pipe_valid[MEM_LAT-1] && !pipe_owner[MEM_LAT-1] && !pipe_killed[MEM_LAT-1];
    l_rvalid = !rst && pipe_valid[MEM_LAT-1] && pipe_owner[MEM_LAT-1];
    f_rdata  = mem_dout;
    l_rdata  = mem_dout;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - scoreboard bench for imem_port_arbiter at MEM_LAT 1, 2 and 3
// Three instances share stimulus; each has its own memory model and response queue.
module tb_imem_port_arbiter;

  typedef struct {
    bit          is_l;
    logic [31:0] data;
    int          grant;
    int          due;
    bit          killed;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_flush, l_req;
  logic [31:0] f_addr, l_addr;

  logic        f_gnt_w [3];
  logic        l_gnt_w [3];
  logic        f_rvalid_w [3];
  logic        l_rvalid_w [3];
  logic [31:0] f_rdata_w [3];
  logic [31:0] l_rdata_w [3];
  logic        mem_cs_w [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] mem_dout_w [3];
  logic [31:0] mp [3][4];

  resp_t q [3][$];
  int    tests = 0;
  int    fails = 0;
  int    t = 0;
  bit    running = 1'b0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt_w[0]),
    .f_rvalid(f_rvalid_w[0]), .f_rdata(f_rdata_w[0]),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt_w[0]),
    .l_rvalid(l_rvalid_w[0]), .l_rdata(l_rdata_w[0]),
    .mem_cs(mem_cs_w[0]), .mem_addr(mem_addr_w[0]), .mem_dout(mem_dout_w[0])
  );
  imem_port_arbiter #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt_w[1]),
    .f_rvalid(f_rvalid_w[1]), .f_rdata(f_rdata_w[1]),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt_w[1]),
    .l_rvalid(l_rvalid_w[1]), .l_rdata(l_rdata_w[1]),
    .mem_cs(mem_cs_w[1]), .mem_addr(mem_addr_w[1]), .mem_dout(mem_dout_w[1])
  );
  imem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt_w[2]),
    .f_rvalid(f_rvalid_w[2]), .f_rdata(f_rdata_w[2]),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt_w[2]),
    .l_rvalid(l_rvalid_w[2]), .l_rdata(l_rdata_w[2]),
    .mem_cs(mem_cs_w[2]), .mem_addr(mem_addr_w[2]), .mem_dout(mem_dout_w[2])
  );

  // Memory word content is 0xD000_0000 | word address, delivered MEM_LAT cycles after cs.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int k = 3; k > 0; k--) mp[d][k] <= mp[d][k-1];
      mp[d][0] <= mem_cs_w[d] ? (32'hD000_0000 | mem_addr_w[d]) : 32'hBAD0_0000;
    end
  end
  assign mem_dout_w[0] = mp[0][0];
  assign mem_dout_w[1] = mp[1][1];
  assign mem_dout_w[2] = mp[2][2];

  bit          m_ef, m_el;
  logic [31:0] m_ed;
  resp_t       m_e;

  always @(negedge clk) begin
    if (running) begin
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() > 0 && q[d][0].due == t) begin
          m_e  = q[d].pop_front();
          m_ef = !m_e.is_l && !m_e.killed;
          m_el = m_e.is_l;
          m_ed = m_e.data;
          tests++;
          if ({f_rvalid_w[d], l_rvalid_w[d]} !== {m_ef, m_el} ||
              (m_ef && f_rdata_w[d] !== m_ed) || (m_el && l_rdata_w[d] !== m_ed)) begin
            fails++;
            $display("FAIL resp lat%0d cyc %0d (granted %0d): got f_rv=%b l_rv=%b f_rd=%h l_rd=%h, want f_rv=%b l_rv=%b data=%h",
                     d + 1, t, m_e.grant, f_rvalid_w[d], l_rvalid_w[d], f_rdata_w[d], l_rdata_w[d], m_ef, m_el, m_ed);
          end
        end else if (f_rvalid_w[d] || l_rvalid_w[d]) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rvalid lat%0d cyc %0d: got f_rv=%b l_rv=%b, want 0 0",
                   d + 1, t, f_rvalid_w[d], l_rvalid_w[d]);
        end
      end
    end
  end

  task automatic step(input bit r, input bit fr, input logic [31:0] fa, input bit fl,
                      input bit lr, input logic [31:0] la,
                      input bit egf, input bit egl, input logic [31:0] ema);
    resp_t e;
    rst = r; f_req = fr; f_addr = fa; f_flush = fl; l_req = lr; l_addr = la;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        q[d].delete();
      end else begin
        if (fl)
          for (int i = 0; i < q[d].size(); i++)
            if (!q[d][i].is_l && q[d][i].due > t) q[d][i].killed = 1'b1;
        if (egf || egl) begin
          e.is_l = egl; e.data = 32'hD000_0000 | ema; e.grant = t; e.due = t + d + 1; e.killed = 1'b0;
          q[d].push_back(e);
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({f_gnt_w[d], l_gnt_w[d], mem_cs_w[d], mem_addr_w[d]} !== {egf, egl, egf | egl, ema}) begin
        fails++;
        $display("FAIL grant lat%0d cyc %0d: got f_gnt=%b l_gnt=%b cs=%b addr=%h, want %b %b %b %h",
                 d + 1, t, f_gnt_w[d], l_gnt_w[d], mem_cs_w[d], mem_addr_w[d], egf, egl, egf | egl, ema);
      end
      if (r) begin
        tests++;
        if (f_rvalid_w[d] !== 1'b0 || l_rvalid_w[d] !== 1'b0) begin
          fails++;
          $display("FAIL rst_rvalid lat%0d cyc %0d: got %b %b, want 0 0", d + 1, t, f_rvalid_w[d], l_rvalid_w[d]);
        end
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; f_flush = 1'b0; l_req = 1'b0; f_addr = '0; l_addr = '0;
    running = 1'b1;
    // reset holds everything low even with requests present
    step(1, 1, 32'h40, 0, 1, 32'h10, 0, 0, 32'h0);
    step(1, 1, 32'h40, 0, 1, 32'h10, 0, 0, 32'h0);
    // F only
    step(0, 1, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
    step(0, 1, 32'h4, 0, 0, 32'h0, 1, 0, 32'h1);
    step(0, 1, 32'h8, 0, 0, 32'h0, 1, 0, 32'h2);
    idle(1);
    // starvation: both rise together, four F grants then forced L
    step(0, 1, 32'h20, 0, 1, 32'h100, 1, 0, 32'h8);
    step(0, 1, 32'h24, 0, 1, 32'h100, 1, 0, 32'h9);
    step(0, 1, 32'h28, 0, 1, 32'h100, 1, 0, 32'hA);
    step(0, 1, 32'h2C, 0, 1, 32'h100, 1, 0, 32'hB);
    step(0, 1, 32'h30, 0, 1, 32'h100, 0, 1, 32'h40);
    step(0, 1, 32'h30, 0, 0, 32'h0, 1, 0, 32'hC);
    idle(1);
    // flush with a same-cycle redirect fetch
    step(0, 1, 32'h10, 0, 0, 32'h0, 1, 0, 32'h4);
    step(0, 1, 32'h14, 0, 0, 32'h0, 1, 0, 32'h5);
    step(0, 1, 32'h236, 1, 0, 32'h0, 1, 0, 32'h8D);
    idle(3);
    // mixed L/F in flight, then flush
    step(0, 0, 32'h0, 0, 1, 32'h54, 0, 1, 32'h15);
    step(0, 1, 32'h58, 0, 0, 32'h0, 1, 0, 32'h16);
    step(0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0);
    idle(2);
    // flush with nothing in flight
    step(0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 32'h0);
    // flush coinciding with a starve-forced L grant
    step(0, 1, 32'h80, 0, 1, 32'h200, 1, 0, 32'h20);
    step(0, 1, 32'h84, 0, 1, 32'h200, 1, 0, 32'h21);
    step(0, 1, 32'h88, 0, 1, 32'h200, 1, 0, 32'h22);
    step(0, 1, 32'h8C, 0, 1, 32'h200, 1, 0, 32'h23);
    step(0, 1, 32'h90, 1, 1, 32'h200, 0, 1, 32'h80);
    step(0, 1, 32'h90, 0, 0, 32'h0, 1, 0, 32'h24);
    idle(3);
    // reset mid-operation drops outstanding responses
    step(0, 1, 32'h300, 0, 0, 32'h0, 1, 0, 32'hC0);
    step(0, 1, 32'h304, 0, 0, 32'h0, 1, 0, 32'hC1);
    step(1, 1, 32'h308, 0, 1, 32'h10, 0, 0, 32'h0);
    step(0, 1, 32'h6014, 0, 0, 32'h0, 1, 0, 32'h1805);
    idle(3);
    // L only
    step(0, 0, 32'h0, 0, 1, 32'h3D6, 0, 1, 32'hF5);
    step(0, 0, 32'h0, 0, 1, 32'h400, 0, 1, 32'h100);
    idle(4);
    running = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (q[d].size() != 0) begin
        fails++;
        $display("FAIL drain lat%0d: got %0d pending responses, want 0", d + 1, q[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
